// File: rtl/ahb_pkg.sv
// Shared AHB-lite types and helpers for the bus arbiter slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  // Re-arbitration is only allowed where no burst is in progress.
  function automatic logic is_boundary(htrans_t t);
    return (t == IDLE) || (t == NONSEQ);
  endfunction

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Bundle of per-master request/address/data lines and the muxed slave-side bus.
interface ahb_bus_arbiter_if
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32
);
  localparam int IDX_W = idx_width(NUM_MASTERS);

  logic    [NUM_MASTERS-1:0]             hbusreq;
  htrans_t [NUM_MASTERS-1:0]             htrans_m;
  logic    [NUM_MASTERS-1:0]             hwrite_m;
  logic    [NUM_MASTERS-1:0][ADDR_W-1:0] haddr_m;
  logic    [NUM_MASTERS-1:0][DATA_W-1:0] hwdata_m;
  logic                                  hready;

  logic    [NUM_MASTERS-1:0] hgrant;
  logic    [IDX_W-1:0]       hmaster;
  logic    [IDX_W-1:0]       hmaster_data;
  htrans_t                   htrans;
  logic                      hwrite;
  logic    [ADDR_W-1:0]      haddr;
  logic    [DATA_W-1:0]      hwdata;

  modport arb (
    input  hbusreq, htrans_m, hwrite_m, haddr_m, hwdata_m, hready,
    output hgrant, hmaster, hmaster_data, htrans, hwrite, haddr, hwdata
  );

  modport master (
    output hbusreq, htrans_m, hwrite_m, haddr_m, hwdata_m,
    input  hready, hgrant, hmaster, hmaster_data
  );

  modport slave (
    input  htrans, hwrite, haddr, hwdata,
    output hready
  );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping to 'last' itself.
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    pick = '0;
    any  = |req;
    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) pick = IDX_W'((int'(last) + i) % N);
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-lite arbiter sharing one slave between NUM_MASTERS masters.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int DEFAULT_MASTER = 0
) (
  input logic          hclk,
  input logic          hresetn,
  ahb_bus_arbiter_if.arb bus
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MASTER);

  logic [IDX_W-1:0]  owner_q, data_owner_q;
  logic [IDX_W-1:0]  rr_pick;
  logic              rr_any;
  htrans_t           owner_trans;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;

  ahb_rr_picker #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_picker (
    .req  (bus.hbusreq),
    .last (owner_q),
    .pick (rr_pick),
    .any  (rr_any)
  );

  assign owner_trans = bus.htrans_m[owner_q];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      owner_q      <= DEF_IDX;
      data_owner_q <= DEF_IDX;
    end else if (bus.hready) begin
      data_owner_q <= owner_q;
      // Bursts (SEQ/BUSY) keep the grant; only IDLE/NONSEQ re-arbitrate.
      if (is_boundary(owner_trans)) owner_q <= rr_any ? rr_pick : DEF_IDX;
    end
  end

  always_comb begin
    bus.hgrant = '0;
    for (int i = 0; i < NUM_MASTERS; i++) bus.hgrant[i] = (owner_q == IDX_W'(i));
  end

  assign addr_mux         = bus.haddr_m[owner_q];
  assign data_mux         = bus.hwdata_m[data_owner_q];

  assign bus.hmaster      = owner_q;
  assign bus.hmaster_data = data_owner_q;
  assign bus.htrans       = hresetn ? owner_trans : IDLE;
  assign bus.hwrite       = bus.hwrite_m[owner_q];
  assign bus.haddr        = addr_mux;
  assign bus.hwdata       = data_mux;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter with a small AHB-lite memory slave model.
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  localparam int NM = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic hclk     = 1'b0;
  logic hresetn  = 1'b0;
  logic slv_busy = 1'b0;
  int   n_cmp    = 0;
  int   n_err    = 0;

  ahb_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .DEFAULT_MASTER(0)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  assign bus.hready = !slv_busy;

  // Slave model: captures address phase, writes memory at the end of the data phase.
  logic [DW-1:0] mem [256];
  logic          dp_valid, dp_write;
  logic [AW-1:0] dp_addr;

  always @(posedge hclk) begin
    if (!hresetn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.hready) begin
      if (dp_valid && dp_write) mem[dp_addr] <= bus.hwdata;
      dp_valid <= (bus.htrans == NONSEQ) || (bus.htrans == SEQ);
      dp_write <= bus.hwrite;
      dp_addr  <= bus.haddr;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NM; i++) begin
      bus.htrans_m[i] = IDLE;
      bus.hwrite_m[i] = 1'b0;
      bus.haddr_m[i]  = '0;
      bus.hwdata_m[i] = '0;
    end
  endtask

  task automatic drive(input int m, input htrans_t t, input logic w, input logic [AW-1:0] a);
    bus.htrans_m[m] = t;
    bus.hwrite_m[m] = w;
    bus.haddr_m[m]  = a;
  endtask

  initial begin
    // Reset with every master requesting and driving NONSEQ.
    bus.hbusreq = 4'b1111;
    idle_all();
    for (int i = 0; i < NM; i++) bus.htrans_m[i] = NONSEQ;
    hresetn = 1'b0;
    repeat (5) tick();
    settle();
    check("rst_hgrant", bus.hgrant, 4'b0001);
    check("rst_hmaster", bus.hmaster, 0);
    check("rst_hmaster_data", bus.hmaster_data, 0);
    check("rst_htrans", bus.htrans, 2'b00);

    // Single request from m2.
    hresetn     = 1'b1;
    bus.hbusreq = 4'b0100;
    idle_all();
    settle();
    check("single_m0_idle", bus.htrans, IDLE);
    tick();
    drive(2, NONSEQ, 1'b1, 8'h0d);
    settle();
    check("single_hmaster", bus.hmaster, 2);
    check("single_hgrant", bus.hgrant, 4'b0100);
    check("single_haddr", bus.haddr, 8'h0d);
    check("single_htrans", bus.htrans, NONSEQ);
    tick();
    drive(2, IDLE, 1'b0, 8'h00);
    bus.hwdata_m[2] = 32'h5a5a_5a5a;
    bus.hbusreq     = 4'b0000;
    settle();
    check("single_hmaster_data", bus.hmaster_data, 2);
    check("single_hwdata", bus.hwdata, 32'h5a5a_5a5a);
    tick();
    settle();
    check("single_mem", mem[8'h0d], 32'h5a5a_5a5a);
    check("single_default", bus.hmaster, 0);

    // Contention: all request, every master NONSEQ read to 'h10+index.
    bus.hbusreq = 4'b1111;
    for (int i = 0; i < NM; i++) drive(i, NONSEQ, 1'b0, AW'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("rr_hmaster_%0d", k), bus.hmaster, k % NM);
      check($sformatf("rr_haddr_%0d", k), bus.haddr, 8'h10 + (k % NM));
      if (k > 0) check($sformatf("rr_hmaster_data_%0d", k), bus.hmaster_data, (k - 1) % NM);
      if (k < 4) tick();
    end

    // Wait state: m1 write 'hfc/'hff with three busy cycles in its data phase.
    idle_all();
    bus.hbusreq = 4'b0010;
    tick();
    drive(1, NONSEQ, 1'b1, 8'hfc);
    settle();
    check("ws_hmaster_addr", bus.hmaster, 1);
    tick();
    drive(1, IDLE, 1'b0, 8'h00);
    bus.hwdata_m[1] = 32'h0000_00ff;
    bus.hbusreq     = 4'b1000;
    slv_busy        = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) slv_busy = 1'b0;
      settle();
      check($sformatf("ws_hgrant_%0d", c), bus.hgrant, 4'b0010);
      check($sformatf("ws_hmaster_%0d", c), bus.hmaster, 1);
      check($sformatf("ws_hmaster_data_%0d", c), bus.hmaster_data, 1);
      check($sformatf("ws_hwdata_%0d", c), bus.hwdata, 32'h0000_00ff);
      check($sformatf("ws_mem_pending_%0d", c), mem[8'hfc], 32'h0);
      tick();
    end
    settle();
    check("ws_mem_written", mem[8'hfc], 32'h0000_00ff);
    check("ws_regrant", bus.hmaster, 3);
    check("ws_hmaster_data_after", bus.hmaster_data, 1);

    // Burst hold: m0 NONSEQ, SEQ, SEQ, IDLE; m3 requests from the first SEQ onward.
    bus.hbusreq = 4'b0001;
    tick();
    drive(0, NONSEQ, 1'b1, 8'h20);
    settle();
    check("burst_nonseq_hmaster", bus.hmaster, 0);
    tick();
    drive(0, SEQ, 1'b1, 8'h24);
    bus.hbusreq = 4'b1001;
    settle();
    check("burst_seq1_hmaster", bus.hmaster, 0);
    check("burst_seq1_htrans", bus.htrans, SEQ);
    tick();
    drive(0, SEQ, 1'b1, 8'h28);
    bus.hbusreq = 4'b1000;
    settle();
    check("burst_seq2_hmaster", bus.hmaster, 0);
    tick();
    drive(0, IDLE, 1'b0, 8'h00);
    settle();
    check("burst_idle_hmaster", bus.hmaster, 0);
    tick();
    settle();
    check("burst_handover_hmaster", bus.hmaster, 3);
    check("burst_handover_hgrant", bus.hgrant, 4'b1000);
    check("burst_handover_data", bus.hmaster_data, 0);

    // Mid-operation reset during m2 data phase.
    bus.hbusreq = 4'b0100;
    tick();
    drive(2, NONSEQ, 1'b1, 8'h40);
    settle();
    check("mr_addr_hmaster", bus.hmaster, 2);
    tick();
    hresetn         = 1'b0;
    bus.hwdata_m[2] = 32'h0000_dead;
    settle();
    check("mr_htrans_forced", bus.htrans, 2'b00);
    check("mr_pre_edge_data", bus.hmaster_data, 2);
    tick();
    settle();
    check("mr_hmaster", bus.hmaster, 0);
    check("mr_hmaster_data", bus.hmaster_data, 0);
    check("mr_htrans", bus.htrans, 2'b00);

    // Release and complete a fresh m2 write.
    hresetn = 1'b1;
    idle_all();
    bus.hbusreq = 4'b0100;
    tick();
    drive(2, NONSEQ, 1'b1, 8'h03);
    settle();
    check("post_hmaster", bus.hmaster, 2);
    check("post_haddr", bus.haddr, 8'h03);
    tick();
    drive(2, IDLE, 1'b0, 8'h00);
    bus.hwdata_m[2] = 32'h0000_0033;
    bus.hbusreq     = 4'b0000;
    settle();
    check("post_hmaster_data", bus.hmaster_data, 2);
    check("post_hwdata", bus.hwdata, 32'h0000_0033);
    tick();
    settle();
    check("post_mem", mem[8'h03], 32'h0000_0033);
    check("post_default", bus.hmaster, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
